// File: rtl/axi_dma_bridge_wide_if.sv
// AXI4 write-channel bundle (AW/W/B) between a write master and the DMA bridge.
// The master modport belongs to the upstream side; the slave modport belongs to the bridge.
interface axi_dma_bridge_wide_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4
);
   logic [ID_WIDTH-1:0]     awid;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;
   logic [ID_WIDTH-1:0]     bid;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/axi_dma_bridge_wide.sv
// Accepts AXI write bursts and splits each wide W beat into 32-bit byte-masked
// words pushed into a DMA FIFO, one lane per cycle, with FIFO-full back-pressure.
//
// state | meaning
// IDLE  | waiting for an AW handshake
// DATA  | waiting for the next W beat
// SPLIT | draining the held beat into the FIFO, one 32-bit lane per cycle
// RESP  | presenting the B response
module axi_dma_bridge_wide #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   axi_dma_bridge_wide_if.slave s_axi,
   output logic [31:0]          dma_fifo_wdata,
   output logic                 dma_fifo_wen,
   input  logic                 dma_fifo_full,
   output logic [31:0]          words_written,
   output logic [15:0]          bursts_done
);
   localparam int LANES  = DATA_WIDTH / 32;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   typedef enum logic [1:0] {IDLE, DATA, SPLIT, RESP} state_t;

   state_t                  state;
   logic [ID_WIDTH-1:0]     awid_q;
   logic [7:0]              len_q;
   logic [7:0]              beat_cnt;
   logic [LANE_W-1:0]       lane;
   logic                    err;
   logic                    last_beat;
   logic [DATA_WIDTH-1:0]   hold_data;
   logic [DATA_WIDTH/8-1:0] hold_strb;

   logic [3:0]  lane_strb;
   logic [31:0] lane_data;
   logic [31:0] lane_word;
   logic        lane_adv;
   logic        beat_is_last;
   logic        bad_aw;
   int          lane_i;

   // Only the decoded ID/length/size/burst matter; the address is never used.
   logic [ADDR_WIDTH-1:0] unused_awaddr;
   assign unused_awaddr = s_axi.awaddr;

   assign s_axi.awready = (state == IDLE);
   assign s_axi.wready  = (state == DATA);
   assign s_axi.bvalid  = (state == RESP);
   assign s_axi.bid     = awid_q;
   assign s_axi.bresp   = (state == RESP && err) ? 2'b10 : 2'b00;

   assign beat_is_last = (beat_cnt == len_q);
   assign bad_aw = s_axi.awburst[1] || ((32'd1 << s_axi.awsize) > 32'(DATA_WIDTH / 8));

   always_comb begin
      lane_i    = int'(lane);
      lane_strb = hold_strb[lane_i*4 +: 4];
      lane_data = hold_data[lane_i*32 +: 32];
      lane_word = '0;
      for (int b = 0; b < 4; b++) begin
         lane_word[b*8 +: 8] = lane_strb[b] ? lane_data[b*8 +: 8] : 8'h00;
      end
   end

   // An empty lane or an errored burst never waits on the FIFO.
   assign lane_adv       = !dma_fifo_full || (lane_strb == 4'h0) || err;
   assign dma_fifo_wen   = (state == SPLIT) && !err && !dma_fifo_full && (lane_strb != 4'h0);
   assign dma_fifo_wdata = (state == SPLIT) ? lane_word : 32'h0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         awid_q        <= '0;
         len_q         <= '0;
         beat_cnt      <= '0;
         lane          <= '0;
         err           <= 1'b0;
         last_beat     <= 1'b0;
         hold_data     <= '0;
         hold_strb     <= '0;
         words_written <= '0;
         bursts_done   <= '0;
      end else begin
         if (dma_fifo_wen) words_written <= words_written + 32'd1;
         case (state)
            IDLE: if (s_axi.awvalid) begin
               awid_q   <= s_axi.awid;
               len_q    <= s_axi.awlen;
               beat_cnt <= '0;
               err      <= bad_aw;
               state    <= DATA;
            end
            DATA: if (s_axi.wvalid) begin
               hold_data <= s_axi.wdata;
               hold_strb <= s_axi.wstrb;
               lane      <= '0;
               last_beat <= s_axi.wlast || beat_is_last;
               beat_cnt  <= beat_cnt + 8'd1;
               if (s_axi.wlast != beat_is_last) err <= 1'b1;
               state     <= SPLIT;
            end
            SPLIT: if (lane_adv) begin
               if (lane == LAST_LANE) begin
                  lane  <= '0;
                  state <= last_beat ? RESP : DATA;
               end else begin
                  lane <= lane + LANE_W'(1);
               end
            end
            RESP: if (s_axi.bready) begin
               err         <= 1'b0;
               bursts_done <= bursts_done + 16'd1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_dma_bridge_wide.sv
// Directed bench for axi_dma_bridge_wide at DATA_WIDTH=64: lane split, strobe
// masking, FIFO back-pressure, protocol errors and mid-burst reset.
module tb_axi_dma_bridge_wide;
   localparam int DW = 64;
   localparam int AW = 32;
   localparam int IW = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] dma_fifo_wdata;
   logic        dma_fifo_wen;
   logic        dma_fifo_full;
   logic [31:0] words_written;
   logic [15:0] bursts_done;

   always #5 clk = ~clk;

   axi_dma_bridge_wide_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) s_axi ();

   axi_dma_bridge_wide #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .s_axi          (s_axi),
      .dma_fifo_wdata (dma_fifo_wdata),
      .dma_fifo_wen   (dma_fifo_wen),
      .dma_fifo_full  (dma_fifo_full),
      .words_written  (words_written),
      .bursts_done    (bursts_done)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] wr_q[$];

   always @(negedge clk) if (rst_n && dma_fifo_wen) wr_q.push_back(dma_fifo_wdata);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_aw(input logic [IW-1:0] id, input logic [7:0] len, input logic [1:0] burst);
      bit ok = 0;
      @(posedge clk); #1;
      s_axi.awid = id; s_axi.awaddr = 32'h1000; s_axi.awlen = len;
      s_axi.awsize = 3'd3; s_axi.awburst = burst; s_axi.awvalid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (s_axi.awready) begin ok = 1; break; end
      end
      if (!ok) check("aw_timeout", 1, 0);
      @(posedge clk); #1;
      s_axi.awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last,
                         input int stall);
      bit ok = 0;
      @(posedge clk); #1;
      s_axi.wdata = data; s_axi.wstrb = strb; s_axi.wlast = last; s_axi.wvalid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (s_axi.wready) begin ok = 1; break; end
      end
      if (!ok) check("w_timeout", 1, 0);
      @(posedge clk); #1;
      s_axi.wvalid = 1'b0;
      if (stall > 0) begin
         // lane0 drains on the next edge; then hold the FIFO full across lane1
         @(posedge clk); #1;
         dma_fifo_full = 1'b1;
         for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_wen", dma_fifo_wen, 0);
            check("stall_wdata", dma_fifo_wdata, data[63:32]);
         end
         @(posedge clk); #1;
         dma_fifo_full = 1'b0;
      end
   endtask

   task automatic get_b(input logic [IW-1:0] exp_id, input logic [1:0] exp_resp);
      bit ok = 0;
      @(posedge clk); #1;
      s_axi.bready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (s_axi.bvalid) begin ok = 1; break; end
      end
      if (!ok) check("b_timeout", 1, 0);
      check("bid", s_axi.bid, exp_id);
      check("bresp", s_axi.bresp, exp_resp);
      @(posedge clk); #1;
      s_axi.bready = 1'b0;
   endtask

   initial begin
      s_axi.awid = '0; s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awsize = '0;
      s_axi.awburst = '0; s_axi.awvalid = 1'b0;
      s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0;
      s_axi.bready = 1'b0; dma_fifo_full = 1'b0;

      #2;
      check("rst_awready", s_axi.awready, 1);
      check("rst_wready", s_axi.wready, 0);
      check("rst_bvalid", s_axi.bvalid, 0);
      check("rst_bresp", s_axi.bresp, 0);
      check("rst_bid", s_axi.bid, 0);
      check("rst_wen", dma_fifo_wen, 0);
      check("rst_wdata", dma_fifo_wdata, 0);
      check("rst_words", words_written, 0);
      check("rst_bursts", bursts_done, 0);
      #10 rst_n = 1'b1;

      // 4-beat INCR burst, full strobes: words 0x10000000..7 in lane order
      send_aw(4'd5, 8'd3, 2'b01);
      for (int k = 0; k < 4; k++)
         send_w({32'h1000_0000 + 32'(2*k+1), 32'h1000_0000 + 32'(2*k)}, 8'hFF, k == 3, 0);
      get_b(4'd5, 2'b00);
      check("b1_count", wr_q.size(), 8);
      for (int k = 0; k < 8; k++)
         if (k < wr_q.size()) check("b1_word", wr_q[k], 32'h1000_0000 + 32'(k));
      check("b1_words", words_written, 8);
      check("b1_bursts", bursts_done, 1);

      // strobe masking
      wr_q.delete();
      send_aw(4'd2, 8'd0, 2'b01);
      send_w(64'h11223344_55667788, 8'h3C, 1'b1, 0);
      get_b(4'd2, 2'b00);
      check("m1_count", wr_q.size(), 2);
      if (wr_q.size() == 2) begin
         check("m1_w0", wr_q[0], 32'h5566_0000);
         check("m1_w1", wr_q[1], 32'h0000_3344);
      end
      wr_q.delete();
      send_aw(4'd3, 8'd0, 2'b00);
      send_w(64'h11223344_55667788, 8'h0F, 1'b1, 0);
      get_b(4'd3, 2'b00);
      check("m2_count", wr_q.size(), 1);
      if (wr_q.size() == 1) check("m2_w0", wr_q[0], 32'h5566_7788);

      // FIFO full for 5 cycles during lane1
      wr_q.delete();
      send_aw(4'd7, 8'd0, 2'b01);
      send_w(64'hCAFEBABE_DEADBEEF, 8'hFF, 1'b1, 5);
      get_b(4'd7, 2'b00);
      check("ff_count", wr_q.size(), 2);
      if (wr_q.size() == 2) begin
         check("ff_w0", wr_q[0], 32'hDEAD_BEEF);
         check("ff_w1", wr_q[1], 32'hCAFE_BABE);
      end
      check("ff_words", words_written, 13);

      // WRAP burst: accepted and drained without FIFO writes
      wr_q.delete();
      send_aw(4'd4, 8'd1, 2'b10);
      send_w(64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 1'b0, 0);
      send_w(64'h1111_2222_3333_4444, 8'hFF, 1'b1, 0);
      get_b(4'd4, 2'b10);
      check("wrap_count", wr_q.size(), 0);
      check("wrap_words", words_written, 13);

      // early WLAST on third beat of a 4-beat burst
      wr_q.delete();
      send_aw(4'd6, 8'd3, 2'b01);
      send_w(64'h0000_0002_0000_0001, 8'hFF, 1'b0, 0);
      send_w(64'h0000_0004_0000_0003, 8'hFF, 1'b0, 0);
      send_w(64'h0000_0006_0000_0005, 8'hFF, 1'b1, 0);
      get_b(4'd6, 2'b10);
      check("early_count", wr_q.size(), 4);
      if (wr_q.size() == 4) check("early_w3", wr_q[3], 32'h0000_0004);
      wr_q.delete();
      send_aw(4'd1, 8'd0, 2'b01);
      send_w(64'h0000_0008_0000_0007, 8'hFF, 1'b1, 0);
      get_b(4'd1, 2'b00);
      check("after_err_count", wr_q.size(), 2);
      check("pre_rst_words", words_written, 19);
      check("pre_rst_bursts", bursts_done, 7);

      // reset mid-SPLIT (FIFO held full so the beat stays in SPLIT)
      send_aw(4'd8, 8'd0, 2'b01);
      @(posedge clk); #1;
      dma_fifo_full = 1'b1;
      s_axi.wdata = 64'h1234_5678_9ABC_DEF0; s_axi.wstrb = 8'hFF; s_axi.wlast = 1'b1;
      s_axi.wvalid = 1'b1;
      @(posedge clk); #1;
      s_axi.wvalid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_words", words_written, 0);
      check("mid_rst_bursts", bursts_done, 0);
      check("mid_rst_awready", s_axi.awready, 1);
      check("mid_rst_bvalid", s_axi.bvalid, 0);
      check("mid_rst_wen", dma_fifo_wen, 0);
      rst_n = 1'b1;
      dma_fifo_full = 1'b0;
      wr_q.delete();
      send_aw(4'd9, 8'd0, 2'b01);
      send_w(64'h0000_00BB_0000_00AA, 8'hFF, 1'b1, 0);
      get_b(4'd9, 2'b00);
      check("post_rst_count", wr_q.size(), 2);
      check("post_rst_words", words_written, 2);
      check("post_rst_bursts", bursts_done, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/axi_dma_bridge_wide.md
AXI_DMA_BRIDGE_WIDE -- requirements
Module: axi_dma_bridge_wide

Interface
REQ-001 Parameter DATA_WIDTH, default 64: AXI write data width; SHALL be a multiple of 32 in 32..256; LANES = DATA_WIDTH/32.
REQ-002 Parameter ADDR_WIDTH, default 32: AXI address width.
REQ-003 Parameter ID_WIDTH, default 4: AXI AWID/BID width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 s_axi_awid/awaddr/awlen/awsize/awburst  input  ID_WIDTH/ADDR_WIDTH/8/3/2  AW payload; awaddr accepted, unused.
REQ-007 s_axi_awvalid input 1 / s_axi_awready output 1  AW handshake.
REQ-008 s_axi_wdata/wstrb/wlast  input  DATA_WIDTH/DATA_WIDTH/8/1  W payload.
REQ-009 s_axi_wvalid input 1 / s_axi_wready output 1  W handshake.
REQ-010 s_axi_bid/bresp  output  ID_WIDTH/2  response; s_axi_bvalid output 1, s_axi_bready input 1.
REQ-011 dma_fifo_wdata  output  32  word to DMA FIFO; dma_fifo_wen  output  1  write strobe; dma_fifo_full  input  1.
REQ-012 words_written  output  32  FIFO writes since reset; bursts_done  output  16  B handshakes since reset.

Function
REQ-013 FSM states IDLE, DATA, SPLIT, RESP; exactly one active.
REQ-014 awready = (state==IDLE); wready = (state==DATA); bvalid = (state==RESP); all decoded from registered state.
REQ-015 IDLE: on awvalid&awready latch awid, awlen, set beat_cnt=0, err = (awburst not INCR/FIXED) or (2^awsize > DATA_WIDTH/8); go DATA.
REQ-016 DATA: on wvalid&wready capture wdata/wstrb into hold regs, lane=0, last_beat = wlast | (beat_cnt==len), beat_cnt+1; go SPLIT.
REQ-017 DATA: err set if wlast != (beat_cnt==len) on the captured beat (early or missing WLAST); that beat terminates the burst.
REQ-018 SPLIT: each lane i (0..LANES-1, ascending) occupies >=1 cycle; lane word = hold_data[32i+31:32i] with bytes whose strobe bit is 0 forced to 0x00.
REQ-019 SPLIT: dma_fifo_wen = !err & !dma_fifo_full & (lane strobe nibble != 0), combinational; dma_fifo_wdata = masked lane word.
REQ-020 SPLIT: lane advances when dma_fifo_full=0 or nibble==0 or err; full with nonzero nibble and !err holds lane, no write, no data loss.
REQ-021 SPLIT: after lane LANES-1 advances go RESP if last_beat else DATA.
REQ-022 err burst: all beats accepted and drained, zero FIFO writes.
REQ-023 RESP: bid = latched awid; bresp = 2'b10 (SLVERR) if err else 2'b00; on bready go IDLE, clear err, bursts_done+1.
REQ-024 words_written +1 per dma_fifo_wen cycle; both counters wrap modulo 2^width.
REQ-025 Throughput: one W beat per LANES+1 cycles maximum; one outstanding burst.

Reset
REQ-026 rst_n low: state=IDLE, beat_cnt=0, lane=0, err=0, hold regs=0, words_written=0, bursts_done=0.
REQ-027 Resulting outputs in reset: awready=1, wready=0, bvalid=0, bresp=00, bid=0, dma_fifo_wen=0, dma_fifo_wdata=0.
REQ-028 Reset mid-burst aborts without response; first cycle after release accepts a new AW.

Verification
REQ-029 DW=64, awid=5, awlen=3, 4 beats wstrb=0xFF -> 8 writes lane0-then-lane1 per beat, words_written=8, bid=5, bresp=00, bursts_done=1.
REQ-030 DW=64, 1 beat wdata=0x11223344_55667788, wstrb=0x3C -> writes 0x55660000 then 0x00003344; wstrb=0x0F -> single write 0x55667788.
REQ-031 dma_fifo_full held 5 cycles during lane1 -> wen=0, lane held, word written on first non-full cycle, value unchanged.
REQ-032 awburst=WRAP, awlen=1, 2 beats -> both beats accepted, 0 writes, bresp=10.
REQ-033 awlen=3, wlast on beat 2 -> burst ends after beat 2 (4 writes at DW=64), bresp=10; next burst returns 00.
REQ-034 rst_n pulsed low mid-SPLIT -> counters 0, awready=1, no bvalid; subsequent awlen=0 burst completes with bresp=00.
